// File: rtl/aes_avl_master.sv
// rtl/aes_avl_master.sv - Avalon-MM master sequencing one decryption on an AES slave
//
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   START             one-cycle request, honoured only in IDLE
//   KEY, MSG_ENC      128-bit key / ciphertext, word 0 in bits [31:0]
//   BUSY, DONE, ERROR operation in progress / completion pulse / timeout flag
//   MSG_DEC           128-bit plaintext read back, word 0 in bits [31:0]
//   AVL_*             Avalon-MM master; AVL_READDATA is zero-latency
//
// Slave map: 0-3 key, 4-7 ciphertext, 8-11 plaintext, 14 start, 15 done (bit 0).
// Optional feature: define AES_AVL_MASTER_TIMEOUT_EN to bound the number of
// done polls at TIMEOUT_POLLS; otherwise POLL waits forever and ERROR is 0.
module aes_avl_master #(
    parameter int unsigned TIMEOUT_POLLS = 4096
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         START,
    input  logic [127:0] KEY,
    input  logic [127:0] MSG_ENC,
    output logic         BUSY,
    output logic         DONE,
    output logic         ERROR,
    output logic [127:0] MSG_DEC,
    output logic         AVL_READ,
    output logic         AVL_WRITE,
    output logic         AVL_CS,
    output logic [3:0]   AVL_BYTE_EN,
    output logic [3:0]   AVL_ADDR,
    output logic [31:0]  AVL_WRITEDATA,
    input  logic [31:0]  AVL_READDATA
);

    typedef enum logic [2:0] {
        IDLE, WR_KEY, WR_MSG, WR_START, POLL, RD_DEC, CLR_START, FIN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  msg_q, msg_d;
    logic [127:0]  dec_q, dec_d;
    logic          rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;
    logic [3:0]    be_q, be_d, addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy_q, busy_d, done_q, done_d;

`ifdef AES_AVL_MASTER_TIMEOUT_EN
    localparam int PCW = $clog2(TIMEOUT_POLLS + 1);
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic           to_q, to_d;
    logic           error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        key_d   = key_q;
        msg_d   = msg_q;
        dec_d   = dec_q;
`ifdef AES_AVL_MASTER_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
        to_d       = to_q;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (START) begin
                    key_d   = KEY;
                    msg_d   = MSG_ENC;
                    wcnt_d  = 2'd0;
                    state_d = WR_KEY;
`ifdef AES_AVL_MASTER_TIMEOUT_EN
                    poll_cnt_d = '0;
                    to_d       = 1'b0;
                    error_d    = 1'b0;
`endif
                end
            end
            WR_KEY: begin
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = WR_MSG;
            end
            WR_MSG: begin
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = WR_START;
            end
            WR_START: state_d = POLL;
            POLL: begin
`ifdef AES_AVL_MASTER_TIMEOUT_EN
                poll_cnt_d = poll_cnt_q + PCW'(1);
`endif
                if (AVL_READDATA[0]) begin
                    state_d = RD_DEC;
                end
`ifdef AES_AVL_MASTER_TIMEOUT_EN
                // Last permitted poll came back not-done: abandon the read-back.
                else if (poll_cnt_q == PCW'(TIMEOUT_POLLS - 1)) begin
                    state_d = CLR_START;
                    to_d    = 1'b1;
                end
`endif
            end
            RD_DEC: begin
                dec_d[{wcnt_q, 5'd0} +: 32] = AVL_READDATA;
                wcnt_d = wcnt_q + 2'd1;
                if (wcnt_q == 2'd3) state_d = CLR_START;
            end
            CLR_START: begin
                state_d = FIN;
`ifdef AES_AVL_MASTER_TIMEOUT_EN
                error_d = to_q;
`endif
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = 4'd0;
        wdata_d = 32'd0;
        case (state_d)
            WR_KEY: begin
                wr_d    = 1'b1;
                addr_d  = {2'b00, wcnt_d};
                wdata_d = key_d[{wcnt_d, 5'd0} +: 32];
            end
            WR_MSG: begin
                wr_d    = 1'b1;
                addr_d  = {2'b01, wcnt_d};
                wdata_d = msg_d[{wcnt_d, 5'd0} +: 32];
            end
            WR_START: begin
                wr_d    = 1'b1;
                addr_d  = 4'd14;
                wdata_d = 32'h1;
            end
            POLL: begin
                rd_d   = 1'b1;
                addr_d = 4'd15;
            end
            RD_DEC: begin
                rd_d   = 1'b1;
                addr_d = {2'b10, wcnt_d};
            end
            CLR_START: begin
                wr_d   = 1'b1;
                addr_d = 4'd14;
            end
            default: ;
        endcase
        cs_d   = rd_d | wr_d;
        be_d   = cs_d ? 4'hF : 4'h0;
        busy_d = (state_d != IDLE) && (state_d != FIN);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            wcnt_q  <= 2'd0;
            key_q   <= '0;
            msg_q   <= '0;
            dec_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cs_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 4'h0;
            wdata_q <= 32'h0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef AES_AVL_MASTER_TIMEOUT_EN
            poll_cnt_q <= '0;
            to_q       <= 1'b0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            key_q   <= key_d;
            msg_q   <= msg_d;
            dec_q   <= dec_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cs_q    <= cs_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef AES_AVL_MASTER_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
            to_q       <= to_d;
            error_q    <= error_d;
`endif
        end
    end

`ifdef AES_AVL_MASTER_TIMEOUT_EN
    assign ERROR = error_q;
`else
    // TIMEOUT_POLLS only shapes the design when the timeout is built in.
    logic unused_timeout_polls;
    assign unused_timeout_polls = |TIMEOUT_POLLS;
    assign ERROR = 1'b0;
`endif

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign MSG_DEC       = dec_q;
    assign AVL_READ      = rd_q;
    assign AVL_WRITE     = wr_q;
    assign AVL_CS        = cs_q;
    assign AVL_BYTE_EN   = be_q;
    assign AVL_ADDR      = addr_q;
    assign AVL_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_aes_avl_master.sv
// tb/tb_aes_avl_master.sv - self-checking bench for aes_avl_master
module tb_aes_avl_master;

    localparam int TO_POLLS = 8;

    logic         CLK = 1'b0;
    logic         RESET, START;
    logic [127:0] KEY, MSG_ENC, MSG_DEC;
    logic         BUSY, DONE, ERROR;
    logic         AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]   AVL_BYTE_EN, AVL_ADDR;
    logic [31:0]  AVL_WRITEDATA, AVL_READDATA;

    always #5 CLK = ~CLK;

    aes_avl_master #(.TIMEOUT_POLLS(TO_POLLS)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .KEY(KEY), .MSG_ENC(MSG_ENC),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .MSG_DEC(MSG_DEC),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   obs_base;

    // Slave model: plaintext registers and a done bit that rises on poll number done_after
    logic [31:0] pt_words [4];
    int          done_after = 0;
    int          poll_base  = 0;
    int          polls_seen = 0;

    assign AVL_READDATA =
        (AVL_READ && AVL_ADDR == 4'hF) ?
            {31'd0, (done_after != 0) && ((polls_seen - poll_base) >= done_after - 1)} :
        (AVL_READ && AVL_ADDR[3:2] == 2'b10) ? pt_words[AVL_ADDR[1:0]] : 32'h0;

    always @(posedge CLK)
        if (AVL_READ && AVL_ADDR == 4'hF) polls_seen <= polls_seen + 1;

    // Bus monitor: every chip-selected cycle is recorded for the scoreboard
    always @(negedge CLK) begin
        txn_t t;
        if (AVL_CS) begin
            t.wr   = AVL_WRITE;
            t.rd   = AVL_READ;
            t.be   = AVL_BYTE_EN;
            t.addr = AVL_ADDR;
            t.data = AVL_WRITE ? AVL_WRITEDATA : 32'h0;
            obs_q.push_back(t);
        end
    end

    function automatic txn_t mk(input bit w, input logic [3:0] a, input logic [31:0] d);
        txn_t t;
        t.wr = w; t.rd = !w; t.be = 4'hF; t.addr = a; t.data = w ? d : 32'h0;
        return t;
    endfunction

    // Expected bus traffic for one operation
    task automatic push_op(input logic [127:0] k, input logic [127:0] m,
                           input int polls, input bit read_back, input bit clear);
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 4'(i), k[32*i +: 32]));
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 4'(4 + i), m[32*i +: 32]));
        exp_q.push_back(mk(1'b1, 4'd14, 32'h1));
        for (int i = 0; i < polls; i++) exp_q.push_back(mk(1'b0, 4'd15, 32'h0));
        if (read_back)
            for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b0, 4'(8 + i), 32'h0));
        if (clear) exp_q.push_back(mk(1'b1, 4'd14, 32'h0));
    endtask

    task automatic set_slave(input logic [127:0] pt, input int after);
        for (int i = 0; i < 4; i++) pt_words[i] = pt[32*i +: 32];
        done_after = after;
        poll_base  = polls_seen;
        obs_base   = obs_q.size();
    endtask

    // Leaves the caller at the first falling edge after the START edge
    task automatic pulse_start(input logic [127:0] k, input logic [127:0] m);
        @(negedge CLK);
        START = 1'b1; KEY = k; MSG_ENC = m;
        @(negedge CLK);
        START = 1'b0;
        KEY = {$urandom, $urandom, $urandom, $urandom};
        MSG_ENC = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        seen = 1'b0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            if (DONE) begin seen = 1'b1; break; end
            @(negedge CLK);
        end
    endtask

    logic [127:0] last_pt;

    task automatic test_reset;
        RESET = 1'b1; START = 1'b0; KEY = '0; MSG_ENC = '0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({BUSY, DONE, ERROR, AVL_READ, AVL_WRITE, AVL_CS} !== 6'b0 ||
            {AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA} !== 40'h0 || MSG_DEC !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b rd=%b wr=%b cs=%b be=%h addr=%h wd=%h dec=%h, expected all zero",
                     BUSY, DONE, ERROR, AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA, MSG_DEC);
        end
        RESET = 1'b0;
        last_pt = '0;
    endtask

    task automatic test_known_vector;
        logic [127:0] k  = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] m  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
        int cyc; bit seen; txn_t e, o;
        set_slave(pt, 10);
        push_op(k, m, 10, 1'b1, 1'b1);
        pulse_start(k, m);
        n_checks++;
        if (BUSY !== 1'b1) begin n_fail++; $display("FAIL known_busy: got %b, expected 1", BUSY); end
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc != 25) begin n_fail++; $display("FAIL known_latency: got seen=%0b cycles=%0d, expected 25", seen, cyc); end
        n_checks++;
        if (MSG_DEC !== pt || BUSY !== 1'b0 || ERROR !== 1'b0) begin
            n_fail++;
            $display("FAIL known_result: got dec=%h busy=%b err=%b, expected dec=%h busy=0 err=0", MSG_DEC, BUSY, ERROR, pt);
        end
        @(negedge CLK);
        n_checks++;
        if (DONE !== 1'b0) begin n_fail++; $display("FAIL known_done_pulse: got %b, expected 0", DONE); end
        n_checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            n_fail++;
            $display("FAIL known_txn_count: got %0d, expected %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_base + i < obs_q.size()) ? obs_q[obs_base + i] : '0;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL known_txn[%0d]: got wr=%b rd=%b be=%h addr=%h data=%h, expected wr=%b rd=%b be=%h addr=%h data=%h",
                         i, o.wr, o.rd, o.be, o.addr, o.data, e.wr, e.rd, e.be, e.addr, e.data);
            end
        end
        last_pt = pt;
    endtask

    task automatic test_first_poll_latency;
        logic [127:0] pt = 128'hfedcba9876543210_0f1e2d3c4b5a6978;
        int cyc; bit seen;
        set_slave(pt, 1);
        push_op(128'h1, 128'h2, 1, 1'b1, 1'b1);
        pulse_start(128'h1, 128'h2);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc != 16) begin n_fail++; $display("FAIL first_poll_latency: got seen=%0b cycles=%0d, expected 16", seen, cyc); end
        n_checks++;
        if (MSG_DEC !== pt) begin n_fail++; $display("FAIL first_poll_dec: got %h, expected %h", MSG_DEC, pt); end
        n_checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            n_fail++;
            $display("FAIL first_poll_txn_count: got %0d, expected %0d", obs_q.size() - obs_base, exp_q.size());
        end
        exp_q.delete();
        last_pt = pt;
    endtask

    task automatic test_start_ignored;
        logic [127:0] k1 = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
        logic [127:0] k2 = 128'h11111111_22222222_33333333_44444444;
        logic [127:0] m  = 128'ha5a5a5a5_5a5a5a5a_00ff00ff_ff00ff00;
        logic [127:0] pt = 128'h0badc0de_13579bdf_2468ace0_76543210;
        int cyc; bit seen, found; txn_t e, o;
        set_slave(pt, 6);
        push_op(k1, m, 6, 1'b1, 1'b1);
        pulse_start(k1, m);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (AVL_READ && AVL_ADDR == 4'hF) found = 1'b1;
            else @(negedge CLK);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL ignore_reach_poll: got no poll, expected poll within 40 cycles"); end
        START = 1'b1; KEY = k2; MSG_ENC = ~m;
        @(negedge CLK);
        START = 1'b0;
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || MSG_DEC !== pt) begin
            n_fail++;
            $display("FAIL ignore_result: got seen=%0b dec=%h, expected seen=1 dec=%h", seen, MSG_DEC, pt);
        end
        repeat (3) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            n_fail++;
            $display("FAIL ignore_txn_count: got %0d, expected %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_base + i < obs_q.size()) ? obs_q[obs_base + i] : '0;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ignore_txn[%0d]: got wr=%b rd=%b addr=%h data=%h, expected wr=%b rd=%b addr=%h data=%h",
                         i, o.wr, o.rd, o.addr, o.data, e.wr, e.rd, e.addr, e.data);
            end
        end
        last_pt = pt;
    endtask

`ifdef AES_AVL_MASTER_TIMEOUT_EN
    task automatic test_timeout;
        logic [127:0] k = 128'h0123_4567_89ab_cdef_0123_4567_89ab_cdef;
        int cyc; bit seen; txn_t e, o;
        set_slave(128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 0);
        push_op(k, ~k, TO_POLLS, 1'b0, 1'b1);
        pulse_start(k, ~k);
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || cyc != 9 + TO_POLLS + 2) begin
            n_fail++;
            $display("FAIL timeout_latency: got seen=%0b cycles=%0d, expected %0d", seen, cyc, 9 + TO_POLLS + 2);
        end
        n_checks++;
        if (ERROR !== 1'b1 || MSG_DEC !== last_pt) begin
            n_fail++;
            $display("FAIL timeout_flags: got err=%b dec=%h, expected err=1 dec=%h", ERROR, MSG_DEC, last_pt);
        end
        n_checks++;
        if (obs_q.size() - obs_base != exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_txn_count: got %0d, expected %0d", obs_q.size() - obs_base, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_base + i < obs_q.size()) ? obs_q[obs_base + i] : '0;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL timeout_txn[%0d]: got wr=%b rd=%b addr=%h data=%h, expected wr=%b rd=%b addr=%h data=%h",
                         i, o.wr, o.rd, o.addr, o.data, e.wr, e.rd, e.addr, e.data);
            end
        end
        // ERROR holds until the next START clears it
        @(negedge CLK);
        n_checks++;
        if (ERROR !== 1'b1) begin n_fail++; $display("FAIL timeout_error_hold: got %b, expected 1", ERROR); end
        set_slave(last_pt, 1);
        pulse_start(k, ~k);
        n_checks++;
        if (ERROR !== 1'b0) begin n_fail++; $display("FAIL timeout_error_clear: got %b, expected 0", ERROR); end
        wait_done(cyc, seen);
        n_checks++;
        if (!seen || ERROR !== 1'b0) begin n_fail++; $display("FAIL timeout_recover: got seen=%0b err=%b, expected seen=1 err=0", seen, ERROR); end
    endtask
`endif

    task automatic test_reset_mid;
        logic [127:0] k  = 128'h77777777_66666666_55555555_44444444;
        logic [127:0] pt = 128'h89abcdef_01234567_fedcba98_76543210;
        bit found; txn_t e, o;
        set_slave(pt, 3);
        push_op(k, ~k, 3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 4'(8 + i), 32'h0));
        pulse_start(k, ~k);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (AVL_READ && AVL_ADDR == 4'hA) found = 1'b1;
            else @(negedge CLK);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL abort_reach_word2: got no read of 10, expected one within 40 cycles"); end
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({BUSY, DONE, ERROR, AVL_READ, AVL_WRITE, AVL_CS} !== 6'b0 ||
            {AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA} !== 40'h0 || MSG_DEC !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b err=%b rd=%b wr=%b cs=%b be=%h addr=%h wd=%h dec=%h, expected all zero",
                     BUSY, DONE, ERROR, AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA, MSG_DEC);
        end
        RESET = 1'b0;
        repeat (8) @(negedge CLK);
        n_checks++;
        if (obs_q.size() - obs_base != exp_q.size() || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_txn_count: got %0d busy=%b, expected %0d busy=0", obs_q.size() - obs_base, BUSY, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = (obs_base + i < obs_q.size()) ? obs_q[obs_base + i] : '0;
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL abort_txn[%0d]: got wr=%b rd=%b addr=%h data=%h, expected wr=%b rd=%b addr=%h data=%h",
                         i, o.wr, o.rd, o.addr, o.data, e.wr, e.rd, e.addr, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_vector();
        test_first_poll_latency();
        test_start_ignored();
`ifdef AES_AVL_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
